// File: rtl/division_issue_controller.sv
// -----------------------------------------------------------------------------
// division_issue_controller
//
// Initiator side of the sequential integer divider. Requests from the issue
// stage are buffered in a small FIFO. Operations are sent to the divider one at
// a time, and each result is handed to writeback in request order together with
// its tag. Divide-by-zero and signed-overflow cases are resolved here without
// using the divider.
//
// Operation encoding (2 bits): 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   bit[1] = remainder requested, bit[0] = unsigned
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   clk_en_i                clock enable; low freezes all state
//   flush_i                 kills buffered and in-flight work
//   req_*                   valid/ready request channel from the issue stage
//   div_*_o                 operands, operation and one-cycle issue pulse
//   div_result_i,
//   div_data_valid_i,
//   div_idle_i              result, result-valid and idle flag from the divider
//   wb_*                    valid/ready result channel to writeback
// -----------------------------------------------------------------------------
module division_issue_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_dividend_i,
    input  logic [DATA_WIDTH-1:0] req_divisor_i,
    input  logic [1:0]            req_operation_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic [DATA_WIDTH-1:0] div_dividend_o,
    output logic [DATA_WIDTH-1:0] div_divisor_o,
    output logic [1:0]            div_operation_o,
    output logic                  div_data_valid_o,
    input  logic [DATA_WIDTH-1:0] div_result_i,
    input  logic                  div_data_valid_i,
    input  logic                  div_idle_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_WIDTH-1:0] wb_result_o,
    output logic [TAG_WIDTH-1:0]  wb_tag_o,
    output logic                  wb_divide_by_zero_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GUARD = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Request FIFO
    logic [DATA_WIDTH-1:0] fifo_dividend_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_divisor_r  [FIFO_DEPTH];
    logic [1:0]            fifo_op_r       [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag_r      [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  ready_r;
    logic                  push_s;
    logic                  pop_s;

    // Head of queue and special-case decode
    logic                  head_valid_s;
    logic [DATA_WIDTH-1:0] head_dividend_s;
    logic [DATA_WIDTH-1:0] head_divisor_s;
    logic [1:0]            head_op_s;
    logic [TAG_WIDTH-1:0]  head_tag_s;
    logic                  zero_s;
    logic                  ovf_s;
    logic                  special_s;
    logic [DATA_WIDTH-1:0] special_result_s;

    // FSM
    state_t                state_r;
    state_t                state_nxt_s;
    logic                  issue_s;
    logic                  bypass_s;
    logic                  capture_s;
    logic                  accept_s;

    // Output / datapath registers
    logic [DATA_WIDTH-1:0] div_dividend_r;
    logic [DATA_WIDTH-1:0] div_divisor_r;
    logic [1:0]            div_op_r;
    logic                  div_valid_r;
    logic [TAG_WIDTH-1:0]  inflight_tag_r;
    logic                  wb_valid_r;
    logic [DATA_WIDTH-1:0] wb_result_r;
    logic [TAG_WIDTH-1:0]  wb_tag_r;
    logic                  wb_dbz_r;

    assign head_valid_s    = (count_r != {CNT_W{1'b0}});
    assign head_dividend_s = fifo_dividend_r[rd_ptr_r];
    assign head_divisor_s  = fifo_divisor_r[rd_ptr_r];
    assign head_op_s       = fifo_op_r[rd_ptr_r];
    assign head_tag_s      = fifo_tag_r[rd_ptr_r];

    // A flushed cycle never enqueues; ready comes from the registered count so
    // a full FIFO cannot push and pop in the same cycle.
    assign push_s = clk_en_i & ~flush_i & req_valid_i & ready_r;
    assign pop_s  = issue_s | bypass_s;

    // Special-case decode on the FIFO head
    always_comb begin
        zero_s           = (head_divisor_s == {DATA_WIDTH{1'b0}});
        ovf_s            = ~head_op_s[0] & (head_dividend_s == MIN_NEG) &
                           (head_divisor_s == {DATA_WIDTH{1'b1}});
        special_s        = zero_s | ovf_s;
        special_result_s = {DATA_WIDTH{1'b0}};
        if (zero_s) begin
            special_result_s = head_op_s[1] ? head_dividend_s : {DATA_WIDTH{1'b1}};
        end else if (ovf_s) begin
            special_result_s = head_op_s[1] ? {DATA_WIDTH{1'b0}} : head_dividend_s;
        end else begin
            special_result_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Next FIFO occupancy
    always_comb begin
        count_nxt_s = count_r;
        if (flush_i) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // FIFO storage, pointers, occupancy and ready flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dividend_r[i] <= {DATA_WIDTH{1'b0}};
                fifo_divisor_r[i]  <= {DATA_WIDTH{1'b0}};
                fifo_op_r[i]       <= 2'b00;
                fifo_tag_r[i]      <= {TAG_WIDTH{1'b0}};
            end
        end else if (clk_en_i) begin
            if (flush_i) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    fifo_dividend_r[wr_ptr_r] <= req_dividend_i;
                    fifo_divisor_r[wr_ptr_r]  <= req_divisor_i;
                    fifo_op_r[wr_ptr_r]       <= req_operation_i;
                    fifo_tag_r[wr_ptr_r]      <= req_tag_i;
                    wr_ptr_r                  <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s != CNT_W'(FIFO_DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else if (clk_en_i) begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (bypass_s) begin
                    state_nxt_s = ST_HOLD;
                end else if (issue_s) begin
                    state_nxt_s = ST_GUARD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            // The divider drops idle one cycle after the pulse, so idle is
            // not trusted here.
            ST_GUARD: begin
                if (flush_i) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            // A result arriving with a flush has been consumed and discarded,
            // so nothing is left to drain: return straight to IDLE.
            ST_WAIT: begin
                if (div_data_valid_i) begin
                    state_nxt_s = flush_i ? ST_IDLE : ST_HOLD;
                end else begin
                    state_nxt_s = flush_i ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush_i || wb_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            // The outstanding result ends the drain even under a fresh flush;
            // otherwise the controller would wait for a result that never comes.
            ST_DRAIN: begin
                if (div_data_valid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        issue_s   = 1'b0;
        bypass_s  = 1'b0;
        capture_s = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!flush_i && head_valid_s) begin
                    if (special_s) begin
                        bypass_s = 1'b1;
                    end else if (div_idle_i) begin
                        issue_s = 1'b1;
                    end else begin
                        issue_s = 1'b0;
                    end
                end else begin
                    bypass_s = 1'b0;
                end
            end
            ST_WAIT:  capture_s = div_data_valid_i & ~flush_i;
            ST_HOLD:  accept_s  = wb_ready_i & ~flush_i;
            default: begin
                issue_s   = 1'b0;
                bypass_s  = 1'b0;
                capture_s = 1'b0;
                accept_s  = 1'b0;
            end
        endcase
    end

    // Divider issue registers and writeback registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_dividend_r <= {DATA_WIDTH{1'b0}};
            div_divisor_r  <= {DATA_WIDTH{1'b0}};
            div_op_r       <= 2'b00;
            div_valid_r    <= 1'b0;
            inflight_tag_r <= {TAG_WIDTH{1'b0}};
            wb_valid_r     <= 1'b0;
            wb_result_r    <= {DATA_WIDTH{1'b0}};
            wb_tag_r       <= {TAG_WIDTH{1'b0}};
            wb_dbz_r       <= 1'b0;
        end else if (clk_en_i) begin
            div_valid_r <= issue_s;
            if (issue_s) begin
                div_dividend_r <= head_dividend_s;
                div_divisor_r  <= head_divisor_s;
                div_op_r       <= head_op_s;
                inflight_tag_r <= head_tag_s;
            end
            if (flush_i) begin
                wb_valid_r <= 1'b0;
            end else if (bypass_s) begin
                wb_valid_r  <= 1'b1;
                wb_result_r <= special_result_s;
                wb_tag_r    <= head_tag_s;
                wb_dbz_r    <= zero_s;
            end else if (capture_s) begin
                wb_valid_r  <= 1'b1;
                wb_result_r <= div_result_i;
                wb_tag_r    <= inflight_tag_r;
                wb_dbz_r    <= 1'b0;
            end else if (accept_s) begin
                wb_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready_o         = ready_r;
    assign div_dividend_o      = div_dividend_r;
    assign div_divisor_o       = div_divisor_r;
    assign div_operation_o     = div_op_r;
    // A frozen pulse must not be seen by the divider while the enable is low.
    assign div_data_valid_o    = div_valid_r & clk_en_i;
    assign wb_valid_o          = wb_valid_r;
    assign wb_result_o         = wb_result_r;
    assign wb_tag_o            = wb_tag_r;
    assign wb_divide_by_zero_o = wb_dbz_r;

endmodule

// File: tb/tb_division_issue_controller.sv
module tb_division_issue_controller;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_dividend_i = 32'd0;
    logic [31:0] req_divisor_i = 32'd0;
    logic [1:0]  req_operation_i = 2'b00;
    logic [5:0]  req_tag_i = 6'd0;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [1:0]  div_operation_o;
    logic        div_data_valid_o;
    logic [31:0] div_result_i;
    logic        div_data_valid_i;
    logic        div_idle_i;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_result_o;
    logic [5:0]  wb_tag_o;
    logic        wb_divide_by_zero_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  tag;
        logic        dbz;
    } exp_t;
    exp_t exp_q[$];

    // Divider model state
    logic        dv_idle;
    logic        dv_busy;
    int          dv_cnt;
    logic [31:0] dv_res;
    int          div_lat = 3;
    bit          lat_rand = 1'b0;
    bit          div_hold = 1'b0;
    int          pulse_cnt = 0;
    logic [31:0] last_dividend = 32'd0;
    logic [31:0] last_divisor = 32'd0;
    logic [1:0]  last_op = 2'b00;

    assign div_idle_i = dv_idle & ~div_hold;

    always #5 clk_i = ~clk_i;

    division_issue_controller #(.DATA_WIDTH(32), .TAG_WIDTH(6), .FIFO_DEPTH(2)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .clk_en_i            (clk_en_i),
        .flush_i             (flush_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_dividend_i      (req_dividend_i),
        .req_divisor_i       (req_divisor_i),
        .req_operation_i     (req_operation_i),
        .req_tag_i           (req_tag_i),
        .div_dividend_o      (div_dividend_o),
        .div_divisor_o       (div_divisor_o),
        .div_operation_o     (div_operation_o),
        .div_data_valid_o    (div_data_valid_o),
        .div_result_i        (div_result_i),
        .div_data_valid_i    (div_data_valid_i),
        .div_idle_i          (div_idle_i),
        .wb_valid_o          (wb_valid_o),
        .wb_ready_i          (wb_ready_i),
        .wb_result_o         (wb_result_o),
        .wb_tag_o            (wb_tag_o),
        .wb_divide_by_zero_o (wb_divide_by_zero_o)
    );

    // Architectural RISC-V result: {divide_by_zero, result}
    function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'd0) return {1'b1, (op[1] ? a : 32'hFFFF_FFFF)};
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, (op[1] ? 32'd0 : a)};
        if (op[0]) return {1'b0, (op[1] ? (a % b) : (a / b))};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {1'b0, (op[1] ? r : q)};
    endfunction

    // Behavioural sequential divider with configurable latency
    always @(posedge clk_i) begin
        if (rst_i) begin
            dv_idle          <= 1'b1;
            dv_busy          <= 1'b0;
            dv_cnt           <= 0;
            dv_res           <= 32'd0;
            div_data_valid_i <= 1'b0;
            div_result_i     <= 32'd0;
        end else if (clk_en_i) begin
            div_data_valid_i <= 1'b0;
            if (div_data_valid_o) begin
                pulse_cnt     <= pulse_cnt + 1;
                last_dividend <= div_dividend_o;
                last_divisor  <= div_divisor_o;
                last_op       <= div_operation_o;
                dv_busy       <= 1'b1;
                dv_idle       <= 1'b0;
                dv_cnt        <= lat_rand ? int'($urandom_range(1, 6)) : div_lat;
                dv_res        <= (div_divisor_o == 32'd0) ? 32'hDEAD_BEEF
                                 : ref_model(div_operation_o, div_dividend_o, div_divisor_o) >> 0;
            end else if (dv_busy) begin
                if (dv_cnt <= 1) begin
                    div_data_valid_i <= 1'b1;
                    div_result_i     <= dv_res;
                    dv_busy          <= 1'b0;
                    dv_idle          <= 1'b1;
                end else begin
                    dv_cnt <= dv_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Drive one request until accepted; called and returns at a falling edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag, input bit expect_wb);
        bit   ok;
        int   n;
        exp_t e;
        logic [32:0] r;
        req_valid_i     = 1'b1;
        req_operation_i = op;
        req_dividend_i  = a;
        req_divisor_i   = b;
        req_tag_i       = tag;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            ok = req_ready_o && clk_en_i;
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
        end
        req_valid_i = 1'b0;
        if (!ok) check("send_accept", 64'(ok), 64'd1);
        if (ok && expect_wb) begin
            r = ref_model(op, a, b);
            e.res = r[31:0];
            e.tag = tag;
            e.dbz = r[32];
            exp_q.push_back(e);
        end
    endtask

    // Wait for a writeback result, compare against the oldest expected one, accept it.
    task automatic retire(input int stall);
        bit   got;
        int   n;
        exp_t e;
        wb_ready_i = 1'b0;
        repeat (stall) @(negedge clk_i);
        got = 1'b0;
        n = 0;
        while (!got && n < 300) begin
            if (wb_valid_o) got = 1'b1;
            else begin
                @(negedge clk_i);
                n++;
            end
        end
        check("wb_valid_seen", 64'(got), 64'd1);
        if (got) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_tag_o), 64'h3F_0000);
            end else begin
                e = exp_q.pop_front();
                check("wb_result", 64'(wb_result_o), 64'(e.res));
                check("wb_tag", 64'(wb_tag_o), 64'(e.tag));
                check("wb_dbz", 64'(wb_divide_by_zero_o), 64'(e.dbz));
            end
            wb_ready_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            wb_ready_i = 1'b0;
        end
    endtask

    task automatic wait_wb_valid();
        int n;
        n = 0;
        while (!wb_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("wb_valid_wait", 64'(wb_valid_o), 64'd1);
    endtask

    initial begin
        int p0;
        int n;
        int hi;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_div_valid", 64'(div_data_valid_o), 64'd0);
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_wb_result", 64'(wb_result_o), 64'd0);
        check("rst_wb_tag", 64'(wb_tag_o), 64'd0);
        check("rst_wb_dbz", 64'(wb_divide_by_zero_o), 64'd0);
        check("rst_div_operands", 64'({div_dividend_o, div_divisor_o}), 64'd0);
        check("rst_div_op", 64'(div_operation_o), 64'd0);

        // DIVU 100/7 through the divider
        p0 = pulse_cnt;
        send(OP_DIVU, 32'd100, 32'd7, 6'd3, 1'b1);
        retire(0);
        check("divu_pulses", 64'(pulse_cnt - p0), 64'd1);
        check("divu_issue_dividend", 64'(last_dividend), 64'd100);
        check("divu_issue_divisor", 64'(last_divisor), 64'd7);
        check("divu_issue_op", 64'(last_op), 64'(OP_DIVU));

        // Divide by zero bypass
        p0 = pulse_cnt;
        send(OP_DIV, 32'd5, 32'd0, 6'd1, 1'b1);
        send(OP_REMU, 32'd5, 32'd0, 6'd2, 1'b1);
        retire(0);
        retire(0);
        check("dbz_no_issue", 64'(pulse_cnt - p0), 64'd0);

        // Signed overflow bypass
        p0 = pulse_cnt;
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd4, 1'b1);
        send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd5, 1'b1);
        retire(1);
        retire(0);
        check("ovf_no_issue", 64'(pulse_cnt - p0), 64'd0);

        // Back-pressure: divider held busy, FIFO fills, writeback stalled
        div_hold = 1'b1;
        p0 = pulse_cnt;
        send(OP_DIVU, 32'd1000, 32'd10, 6'd7, 1'b1);
        send(OP_DIV, 32'hFFFF_FFCE, 32'd7, 6'd8, 1'b1);
        check("full_ready_low", 64'(req_ready_o), 64'd0);
        repeat (3) @(negedge clk_i);
        check("busy_no_issue", 64'(pulse_cnt - p0), 64'd0);
        div_hold = 1'b0;
        send(OP_REMU, 32'd77, 32'd5, 6'd9, 1'b1);
        wait_wb_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_valid", 64'(wb_valid_o), 64'd1);
            check("stall_result", 64'(wb_result_o), 64'(exp_q[0].res));
            check("stall_tag", 64'(wb_tag_o), 64'(exp_q[0].tag));
        end
        retire(0);
        retire(2);
        retire(1);

        // Flush while waiting on the divider
        div_lat = 8;
        p0 = pulse_cnt;
        send(OP_REM, 32'd9, 32'd4, 6'd10, 1'b0);
        n = 0;
        while (pulse_cnt == p0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("flush_issue_seen", 64'(pulse_cnt - p0), 64'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (wb_valid_o) hi++;
        end
        check("drain_no_wb", 64'(hi), 64'd0);
        div_lat = 3;
        send(OP_DIVU, 32'd9, 32'd4, 6'd11, 1'b1);
        retire(0);

        // Flush coinciding with a request on an empty FIFO
        p0 = pulse_cnt;
        req_valid_i = 1'b1;
        req_operation_i = OP_DIVU;
        req_dividend_i = 32'd50;
        req_divisor_i = 32'd5;
        req_tag_i = 6'd12;
        flush_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (wb_valid_o) hi++;
        end
        check("drop_ready", 64'(req_ready_o), 64'd1);
        check("drop_no_wb", 64'(hi), 64'd0);
        check("drop_no_issue", 64'(pulse_cnt - p0), 64'd0);
        send(OP_DIVU, 32'd8, 32'd2, 6'd13, 1'b1);
        retire(0);

        // Clock enable freezes issue and writeback handshake
        p0 = pulse_cnt;
        send(OP_DIV, 32'hFFFF_FF9C, 32'd3, 6'd14, 1'b1);
        clk_en_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("en_low_no_issue", 64'(pulse_cnt - p0), 64'd0);
        clk_en_i = 1'b1;
        wait_wb_valid();
        clk_en_i = 1'b0;
        wb_ready_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("en_low_wb_held", 64'(wb_valid_o), 64'd1);
        wb_ready_i = 1'b0;
        clk_en_i = 1'b1;
        retire(0);

        // Randomized traffic against the reference model
        lat_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    a = $urandom;
                    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
                    case ($urandom_range(0, 5))
                        0:       b = 32'd0;
                        1:       b = 32'hFFFF_FFFF;
                        2:       b = $urandom_range(1, 15);
                        default: b = $urandom;
                    endcase
                    send(2'($urandom_range(0, 3)), a, b, 6'(i + 20), 1'b1);
                    repeat ($urandom_range(0, 2)) @(negedge clk_i);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    retire($urandom_range(0, 3));
                end
            end
        join
        repeat (5) @(negedge clk_i);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_wb_idle", 64'(wb_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
